// File: rtl/uop_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// uop_fetch_stage_pkg : shared types and constants for the microcode front end
// Rev 1.0
// ============================================================================
package uop_fetch_stage_pkg;

    localparam int UOP_BUF_SIZE     = 256;
    localparam int INSTR_WIDTH      = 32;
    localparam int UOP_BUF_WIDTH    = 2 * INSTR_WIDTH;
    localparam int BRANCH_TAG_WIDTH = 4;
    localparam int UOP_ADDR_WIDTH   = $clog2(UOP_BUF_SIZE);

    localparam logic [3:0] BRANCH_OPCODE = 4'hB;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0]      instruction;
        logic [BRANCH_TAG_WIDTH-1:0] branch_tag;
    } fetched_instruction;

    function automatic logic is_branch(input logic [INSTR_WIDTH-1:0] instr);
        return instr[INSTR_WIDTH-1 -: 4] == BRANCH_OPCODE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uop_branch_tagger.sv
`default_nettype none
// ============================================================================
// uop_branch_tagger : branch detection and tag assignment for one fetch pair
// Rev 1.0
// ============================================================================
module uop_branch_tagger
    import uop_fetch_stage_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0]      instr_1_i,
    input  logic [INSTR_WIDTH-1:0]      instr_2_i,
    input  logic [BRANCH_TAG_WIDTH-1:0] tag_i,
    output logic [BRANCH_TAG_WIDTH-1:0] tag_1_o,
    output logic [BRANCH_TAG_WIDTH-1:0] tag_2_o,
    output logic [BRANCH_TAG_WIDTH-1:0] tag_next_o
);

    logic w_br_1;
    logic w_br_2;

    assign w_br_1 = is_branch(instr_1_i);
    assign w_br_2 = is_branch(instr_2_i);

    // The younger instruction is speculative past an older branch in the pair
    assign tag_1_o    = tag_i;
    assign tag_2_o    = tag_i   + {{(BRANCH_TAG_WIDTH-1){1'b0}}, w_br_1};
    assign tag_next_o = tag_2_o + {{(BRANCH_TAG_WIDTH-1){1'b0}}, w_br_2};

endmodule
`default_nettype wire

// File: rtl/uop_fetch_stage.sv
`default_nettype none
// ============================================================================
// uop_fetch_stage : fetches two micro-ops per line, tags branches, valid/stall out
// Rev 1.0
// ============================================================================
module uop_fetch_stage
    import uop_fetch_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      prev_valid,
    input  logic                      next_stalled,
    input  logic [UOP_BUF_WIDTH-1:0]  uop,
    output logic [UOP_ADDR_WIDTH-1:0] uop_addr,
    output logic                      valid,
    output logic                      stalled,
    output fetched_instruction        instruction_1,
    output fetched_instruction        instruction_2
);

    logic [UOP_ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [BRANCH_TAG_WIDTH-1:0] tag_q, tag_d;
    logic                        valid_q, valid_d;
    fetched_instruction          instr_1_q, instr_1_d;
    fetched_instruction          instr_2_q, instr_2_d;

    logic                        w_advance;
    logic [INSTR_WIDTH-1:0]      w_uop_1;
    logic [INSTR_WIDTH-1:0]      w_uop_2;
    logic [BRANCH_TAG_WIDTH-1:0] w_tag_1;
    logic [BRANCH_TAG_WIDTH-1:0] w_tag_2;
    logic [BRANCH_TAG_WIDTH-1:0] w_tag_next;
    logic [UOP_ADDR_WIDTH-1:0]   w_pc_inc;

    assign w_uop_1 = uop[INSTR_WIDTH-1:0];
    assign w_uop_2 = uop[UOP_BUF_WIDTH-1:INSTR_WIDTH];

    assign stalled   = valid_q & next_stalled;
    assign w_advance = prev_valid & ~stalled & ~clear;

    // Explicit wrap keeps non-power-of-two buffer sizes correct
    assign w_pc_inc = (pc_q == UOP_ADDR_WIDTH'(UOP_BUF_SIZE - 1))
                    ? '0 : pc_q + UOP_ADDR_WIDTH'(1);

    uop_branch_tagger u_tagger (
        .instr_1_i  (w_uop_1),
        .instr_2_i  (w_uop_2),
        .tag_i      (tag_q),
        .tag_1_o    (w_tag_1),
        .tag_2_o    (w_tag_2),
        .tag_next_o (w_tag_next)
    );

    always_comb begin
        pc_d      = pc_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        instr_1_d = instr_1_q;
        instr_2_d = instr_2_q;
        if (clear) begin
            pc_d    = '0;
            tag_d   = '0;
            valid_d = 1'b0;
        end else if (w_advance) begin
            pc_d      = w_pc_inc;
            tag_d     = w_tag_next;
            valid_d   = 1'b1;
            instr_1_d = '{instruction: w_uop_1, branch_tag: w_tag_1};
            instr_2_d = '{instruction: w_uop_2, branch_tag: w_tag_2};
        end else if (!stalled) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            instr_1_q <= '0;
            instr_2_q <= '0;
        end else begin
            pc_q      <= pc_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            instr_1_q <= instr_1_d;
            instr_2_q <= instr_2_d;
        end
    end

    assign uop_addr      = pc_q;
    assign valid         = valid_q;
    assign instruction_1 = instr_1_q;
    assign instruction_2 = instr_2_q;

endmodule
`default_nettype wire

// File: tb/tb_uop_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_uop_fetch_stage : directed vectors for the micro-op fetch stage
// Rev 1.0
// ============================================================================
module tb_uop_fetch_stage;
    import uop_fetch_stage_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      clear;
    logic                      prev_valid;
    logic                      next_stalled;
    logic [UOP_BUF_WIDTH-1:0]  uop;
    logic [UOP_ADDR_WIDTH-1:0] uop_addr;
    logic                      valid;
    logic                      stalled;
    fetched_instruction        instruction_1;
    fetched_instruction        instruction_2;

    logic [UOP_BUF_WIDTH-1:0]  mem [UOP_BUF_SIZE];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pv, ns, cl, pl;
        logic        ev, es;
        logic [7:0]  ea;
        logic [31:0] i1;
        logic [3:0]  t1;
        logic [31:0] i2;
        logic [3:0]  t2;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    assign uop = mem[uop_addr];

    uop_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .prev_valid    (prev_valid),
        .next_stalled  (next_stalled),
        .uop           (uop),
        .uop_addr      (uop_addr),
        .valid         (valid),
        .stalled       (stalled),
        .instruction_1 (instruction_1),
        .instruction_2 (instruction_2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic pv, ns, cl, pl, ev, es, input logic [7:0] ea,
                                input logic [31:0] i1, input logic [3:0] t1,
                                input logic [31:0] i2, input logic [3:0] t2);
        vec_t v;
        v.pv = pv; v.ns = ns; v.cl = cl; v.pl = pl;
        v.ev = ev; v.es = es; v.ea = ea;
        v.i1 = i1; v.t1 = t1; v.i2 = i2; v.t2 = t2;
        return v;
    endfunction

    initial begin
        // Buffer image: plain lines, one double-branch line early, a branch run later
        for (int i = 0; i < UOP_BUF_SIZE; i++)
            mem[i] = {32'h2000_0000 | 32'(i), 32'h1000_0000 | 32'(i)};
        mem[0] = 64'h00000002_00000001;
        mem[2] = {32'hB000_0000, 32'hB000_0000};
        for (int i = 5; i <= 10; i++)
            mem[i] = {32'hB000_0000 | 32'(i), 32'hB000_0000 | 32'(i)};
        mem[11] = {32'h2000_000B, 32'hB000_0011};
        mem[12] = {32'hB000_0000, 32'hB000_0000};

        //             pv ns cl pl ev es addr  i1            t1  i2            t2
        vecs[0]  = mk(1, 0, 0, 1, 1, 0, 8'd1, 32'h0000_0001, 0, 32'h0000_0002, 0);
        vecs[1]  = mk(1, 0, 0, 1, 1, 0, 8'd2, 32'h1000_0001, 0, 32'h2000_0001, 0);
        vecs[2]  = mk(1, 0, 0, 1, 1, 0, 8'd3, 32'hB000_0000, 0, 32'hB000_0000, 1);
        vecs[3]  = mk(1, 1, 0, 1, 1, 1, 8'd3, 32'hB000_0000, 0, 32'hB000_0000, 1);
        vecs[4]  = mk(1, 1, 0, 1, 1, 1, 8'd3, 32'hB000_0000, 0, 32'hB000_0000, 1);
        vecs[5]  = mk(1, 1, 0, 1, 1, 1, 8'd3, 32'hB000_0000, 0, 32'hB000_0000, 1);
        vecs[6]  = mk(1, 0, 0, 1, 1, 0, 8'd4, 32'h1000_0003, 2, 32'h2000_0003, 2);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 8'd4, 32'h0,         0, 32'h0,         0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 0, 8'd4, 32'h0,         0, 32'h0,         0);
        vecs[9]  = mk(1, 0, 0, 1, 1, 0, 8'd5, 32'h1000_0004, 2, 32'h2000_0004, 2);
        vecs[10] = mk(1, 1, 1, 0, 0, 0, 8'd0, 32'h0,         0, 32'h0,         0);
        vecs[11] = mk(1, 0, 0, 1, 1, 0, 8'd1, 32'h0000_0001, 0, 32'h0000_0002, 0);

        reset        = 1'b0;
        clear        = 1'b0;
        prev_valid   = 1'b1;
        next_stalled = 1'b0;
        #3;
        chk("reset_valid",   32'(valid),                    32'd0);
        chk("reset_stalled", 32'(stalled),                  32'd0);
        chk("reset_addr",    32'(uop_addr),                 32'd0);
        chk("reset_i1",      instruction_1.instruction,     32'd0);
        chk("reset_i2",      instruction_2.instruction,     32'd0);
        chk("reset_t1",      32'(instruction_1.branch_tag), 32'd0);
        chk("reset_t2",      32'(instruction_2.branch_tag), 32'd0);
        step();
        step();
        reset = 1'b1;

        for (int v = 0; v < 12; v++) begin
            prev_valid   = vecs[v].pv;
            next_stalled = vecs[v].ns;
            clear        = vecs[v].cl;
            step();
            chk($sformatf("v%0d_valid", v),   32'(valid),    32'(vecs[v].ev));
            chk($sformatf("v%0d_stalled", v), 32'(stalled),  32'(vecs[v].es));
            chk($sformatf("v%0d_addr", v),    32'(uop_addr), 32'(vecs[v].ea));
            if (vecs[v].pl) begin
                chk($sformatf("v%0d_i1", v), instruction_1.instruction,     vecs[v].i1);
                chk($sformatf("v%0d_t1", v), 32'(instruction_1.branch_tag), 32'(vecs[v].t1));
                chk($sformatf("v%0d_i2", v), instruction_2.instruction,     vecs[v].i2);
                chk($sformatf("v%0d_t2", v), 32'(instruction_2.branch_tag), 32'(vecs[v].t2));
            end
        end

        // Full sweep from line 1 around to line 0, including the 15 -> 0 tag wrap
        prev_valid   = 1'b1;
        next_stalled = 1'b0;
        clear        = 1'b0;
        for (int k = 1; k < UOP_BUF_SIZE; k++) begin
            step();
            chk($sformatf("wrap%0d_i1", k),   instruction_1.instruction, mem[k][31:0]);
            chk($sformatf("wrap%0d_addr", k), 32'(uop_addr),             32'((k + 1) % UOP_BUF_SIZE));
            if (k == 11) begin
                chk("tag_l11_t1", 32'(instruction_1.branch_tag), 32'd14);
                chk("tag_l11_t2", 32'(instruction_2.branch_tag), 32'd15);
            end
            if (k == 12) begin
                chk("tag_l12_t1", 32'(instruction_1.branch_tag), 32'd15);
                chk("tag_l12_t2", 32'(instruction_2.branch_tag), 32'd0);
            end
            if (k == 13) begin
                chk("tag_l13_t1", 32'(instruction_1.branch_tag), 32'd1);
                chk("tag_l13_t2", 32'(instruction_2.branch_tag), 32'd1);
            end
        end
        step();
        chk("refetch_i1",   instruction_1.instruction, 32'h0000_0001);
        chk("refetch_i2",   instruction_2.instruction, 32'h0000_0002);
        chk("refetch_addr", 32'(uop_addr),             32'd1);
        chk("refetch_valid", 32'(valid),               32'd1);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b0;
        #1;
        chk("areset_valid", 32'(valid),                32'd0);
        chk("areset_addr",  32'(uop_addr),             32'd0);
        chk("areset_i1",    instruction_1.instruction, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("post_reset_valid", 32'(valid),                    32'd1);
        chk("post_reset_i1",    instruction_1.instruction,     32'h0000_0001);
        chk("post_reset_t2",    32'(instruction_2.branch_tag), 32'd0);
        chk("post_reset_addr",  32'(uop_addr),                 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
